regfile_dump_reader: RTL and testbench

Read-side sequencer for the 16×32 register file. On a start pulse it walks a contiguous, wrap-around range of register indices, drives the file's read-select into the 16:1 read mux and captures the returned word. Each word is streamed out over a valid/ready interface with its index and a last flag. It complements the decoder/load write path and is used for debug dump, context save and scan-out.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_idx_counter.sv | 32 +++
 rtl/regfile_dump_reader.sv | 111 +++++++++++
 tb/tb_regfile_dump_reader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and dump FSM state type for the 16x32 register file and its
// read/write sequencers.
package regfile_pkg;

   localparam int unsigned NREGS = 16;
   localparam int unsigned AW    = $clog2(NREGS);
   localparam int unsigned DW    = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } dump_state_t;

endpackage

// File: rtl/regfile_idx_counter.sv
// AW-bit register index counter: load, increment with mod-NREGS wrap, and a
// compare against the final index of the current range.
module regfile_idx_counter
   import regfile_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_load,
   input  logic [AW-1:0] i_load_val,
   input  logic          i_inc,
   input  logic [AW-1:0] i_last,
   output logic [AW-1:0] o_cnt,
   output logic          o_match
);

   logic [AW-1:0] r_cnt;

   // NREGS is a power of two, so natural AW-bit overflow is the wrap.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_inc) begin
         r_cnt <= r_cnt + AW'(1);
      end
   end

   assign o_cnt   = r_cnt;
   assign o_match = (r_cnt == i_last);

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side dump sequencer: walks a wrap-around index range through the register
// file read mux and streams each word out over valid/ready with index and last flag.
module regfile_dump_reader
   import regfile_pkg::*;
(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_start,
   input  logic          i_abort,
   input  logic [AW-1:0] i_first_idx,
   input  logic [AW-1:0] i_last_idx,
   output logic [AW-1:0] o_rd_sel,
   input  logic [DW-1:0] i_rd_data,
   output logic          o_out_valid,
   input  logic          i_out_ready,
   output logic [DW-1:0] o_out_data,
   output logic [AW-1:0] o_out_idx,
   output logic          o_out_last,
   output logic          o_busy,
   output logic          o_done
);

   dump_state_t   r_state;
   logic [AW-1:0] r_last;
   logic          r_out_valid;
   logic [DW-1:0] r_out_data;
   logic [AW-1:0] r_out_idx;
   logic          r_out_last;
   logic          r_done;

   logic [AW-1:0] w_cur;
   logic          w_match;
   logic          w_load;
   logic          w_inc;
   logic          w_take;

   // Output slot is free when empty or being drained this cycle.
   assign w_take = !r_out_valid || i_out_ready;
   assign w_load = (r_state == IDLE) && i_start && !i_abort;
   assign w_inc  = (r_state == RUN) && !i_abort && w_take && !w_match;

   regfile_idx_counter u_idx_counter (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_load),
      .i_load_val (i_first_idx),
      .i_inc      (w_inc),
      .i_last     (r_last),
      .o_cnt      (w_cur),
      .o_match    (w_match)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_last      <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_idx   <= '0;
         r_out_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (i_start && !i_abort) begin
                  r_last  <= i_last_idx;
                  r_state <= RUN;
               end
            end
            RUN: begin
               if (i_abort) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_state     <= IDLE;
               end else if (w_take) begin
                  r_out_data  <= i_rd_data;
                  r_out_idx   <= w_cur;
                  r_out_last  <= w_match;
                  r_out_valid <= 1'b1;
                  if (w_match) begin
                     r_state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (i_abort) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_state     <= IDLE;
               end else if (r_out_valid && i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Counter holds in IDLE, so rd_sel keeps its last value between dumps.
   assign o_rd_sel    = w_cur;
   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_idx   = r_out_idx;
   assign o_out_last  = r_out_last;
   assign o_busy      = (r_state != IDLE);
   assign o_done      = r_done;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader against a preloaded 16x32 register model.
module tb_regfile_dump_reader;
   import regfile_pkg::*;

   typedef struct {
      logic [AW-1:0] idx;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [AW-1:0] first_idx;
   logic [AW-1:0] last_idx;
   logic [AW-1:0] rd_sel;
   logic [DW-1:0] rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_idx;
   logic          out_last;
   logic          busy;
   logic          done;

   logic [DW-1:0] mem [NREGS];
   beat_t         q[$];
   int            n_err = 0;
   int            n_chk = 0;
   int            ready_mode = 0;
   int            ready_k = 0;
   logic [5:0]    ready_pat = 6'b101001;

   logic          exp_done = 1'b0;
   logic          prev_stall = 1'b0;
   logic          prev_abort = 1'b0;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] prev_idx;
   logic          prev_last;
   beat_t         mb;

   always #5 clk = ~clk;
   assign rd_data = mem[rd_sel];

   regfile_dump_reader dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start),
      .i_abort     (abort),
      .i_first_idx (first_idx),
      .i_last_idx  (last_idx),
      .o_rd_sel    (rd_sel),
      .i_rd_data   (rd_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_data  (out_data),
      .o_out_idx   (out_idx),
      .o_out_last  (out_last),
      .o_busy      (busy),
      .o_done      (done)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (ready_mode == 1) begin
         out_ready = ready_pat[ready_k % 6];
         ready_k++;
      end else begin
         out_ready = 1'b1;
      end
   end

   // Negedge monitor: done timing, stall stability, and beat scoreboard.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_done   = 1'b0;
         prev_stall = 1'b0;
         prev_abort = 1'b0;
      end else begin
         if (prev_stall && !prev_abort) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_idx", out_idx, prev_idx);
            chk("stall_last", out_last, prev_last);
         end
         chk("done", done, exp_done);
         exp_done = out_valid && out_ready && out_last && !abort;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               chk("sb_extra_beat", q.size(), 1);
            end else begin
               mb = q.pop_front();
               chk("beat_idx", out_idx, mb.idx);
               chk("beat_data", out_data, mb.data);
               chk("beat_last", out_last, mb.last);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_abort = abort;
         prev_data  = out_data;
         prev_idx   = out_idx;
         prev_last  = out_last;
      end
   end

   task automatic push_dump(input logic [AW-1:0] f, input logic [AW-1:0] l);
      int len;
      beat_t b;
      len = ((int'(l) - int'(f)) & (NREGS - 1)) + 1;
      for (int i = 0; i < len; i++) begin
         b.idx  = AW'((int'(f) + i) % NREGS);
         b.data = 32'h1000 + DW'(b.idx);
         b.last = (i == len - 1);
         q.push_back(b);
      end
   endtask

   task automatic do_start(input logic [AW-1:0] f, input logic [AW-1:0] l);
      @(posedge clk);
      #1;
      start     = 1'b1;
      first_idx = f;
      last_idx  = l;
      push_dump(f, l);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("rd_sel_first", rd_sel, f);
      chk("valid_lat0", out_valid, 0);
      @(posedge clk);
      #1;
      chk("valid_lat1", out_valid, 1);
      chk("idx_lat1", out_idx, f);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("idle_timeout", busy, 0);
      chk("sb_drained", q.size(), 0);
   endtask

   task automatic wait_idx(input logic [AW-1:0] v, input int budget);
      int n = 0;
      while (!(out_valid && out_idx == v) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("wait_idx_timeout", out_valid && out_idx == v, 1);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_sel", rd_sel, 0);
      chk("rst_data", out_data, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_last", out_last, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      first_idx = '0;
      last_idx  = '0;
      out_ready = 1'b1;
      for (int i = 0; i < NREGS; i++) mem[i] = 32'h1000 + DW'(i);
      #12;
      chk_reset_outputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Full 16-beat dump.
      do_start(4'd0, 4'd15);
      wait_idle(60);

      // Wrap-around range 14,15,0,1.
      do_start(4'd14, 4'd1);
      wait_idle(30);

      // Single beat: busy for exactly two cycles, then done.
      do_start(4'd7, 4'd7);
      @(posedge clk);
      #1;
      chk("single_busy_end", busy, 0);
      chk("single_done", done, 1);
      wait_idle(5);

      // Backpressure with toggling ready.
      ready_mode = 1;
      ready_k    = 0;
      do_start(4'd0, 4'd5);
      wait_idle(60);
      ready_mode = 0;

      // Start while busy is ignored; abort mid-dump.
      do_start(4'd0, 4'd15);
      wait_idx(4'd3, 20);
      start     = 1'b1;
      first_idx = 4'd9;
      last_idx  = 4'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_idx(4'd5, 20);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      chk("abort_valid", out_valid, 0);
      chk("abort_busy", busy, 0);
      q.delete();
      repeat (3) @(posedge clk);
      #1;
      chk("abort_still_idle", busy, 0);
      do_start(4'd2, 4'd3);
      wait_idle(20);

      // Asynchronous reset mid-dump.
      do_start(4'd0, 4'd15);
      wait_idx(4'd4, 20);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_start(4'd3, 4'd4);
      wait_idle(20);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
